// File: rtl/rstk_stack.sv
// rtl/rstk_stack.sv - LIFO register stack with wrap-on-overflow and combinational top-of-stack
//
// Purpose:
//   A DEPTH-entry circular buffer used as a register-mapped stack.
//   A load strobe pushes data_in. A read strobe pops.
//   When the stack is full, a push overwrites the oldest entry so that the newest DEPTH entries survive.
//
// Ports:
//   sysclk     in   system clock, rising edge
//   sysreset   in   asynchronous active-low reset
//   data_out   out  current top-of-stack, 0 when empty
//   data_in    in   value to push or to replace the top with
//   load       in   push strobe
//   read       in   pop strobe
//   depth      out  number of valid entries, 0..DEPTH
//   empty      out  depth == 0
//   full       out  depth == DEPTH
//   err_clear  in   clears sticky flags            (RSTK_STACK_ERR_EN only)
//   overflow   out  sticky push-when-full flag     (RSTK_STACK_ERR_EN only)
//   underflow  out  sticky pop-when-empty flag     (RSTK_STACK_ERR_EN only)
//
// Configuration macro: RSTK_STACK_ERR_EN enables the sticky error-flag logic and its ports.

module rstk_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       sysclk,
    input  logic                       sysreset,
    output logic [WIDTH-1:0]           data_out,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       load,
    input  logic                       read,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
`ifdef RSTK_STACK_ERR_EN
    output logic                       full,
    input  logic                       err_clear,
    output logic                       overflow,
    output logic                       underflow
`else
    output logic                       full
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] TOP_MAX = PW'(DEPTH - 1);
    localparam logic [DW-1:0] CNT_MAX = DW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top;
    logic [DW-1:0]    cnt;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_MAX);

    // Explicit wrap so that DEPTH does not have to be a power of two.
    assign ptr_inc = (top == TOP_MAX) ? '0 : top + 1'b1;
    assign ptr_dec = (top == '0) ? TOP_MAX : top - 1'b1;

    // Asserting load and read together on an empty stack counts as a plain push.
    // On a non-empty stack the same combination rewrites the top entry in place.
    assign do_push = load & (~read | is_empty);
    assign do_repl = load & read & ~is_empty;
    assign do_pop  = read & ~load & ~is_empty;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            top <= '0;
            cnt <= '0;
        end else if (do_push) begin
            top <= ptr_inc;
            if (!is_full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (do_pop) begin
            top <= ptr_dec;
            cnt <= cnt - 1'b1;
        end
    end

    // The storage array is not reset.
    // Stale entries stay hidden because data_out is gated to 0 while the stack is empty.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[ptr_inc] <= data_in;
        end else if (do_repl) begin
            mem[top] <= data_in;
        end
    end

    assign data_out = is_empty ? '0 : mem[top];
    assign depth    = cnt;
    assign empty    = is_empty;
    assign full     = is_full;

`ifdef RSTK_STACK_ERR_EN
    logic ovf_evt;
    logic udf_evt;

    assign ovf_evt = load & ~read & is_full;
    assign udf_evt = read & ~load & is_empty;

    // When a new event and err_clear arrive on the same edge, the event wins.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rstk_stack.sv
// tb/tb_rstk_stack.sv - scoreboard testbench for rstk_stack against a queue-based stack model

module tb_rstk_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             sysclk;
    logic             sysreset;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             read;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err_clear;
`ifdef RSTK_STACK_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    rstk_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .data_out  (data_out),
        .data_in   (data_in),
        .load      (load),
        .read      (read),
        .depth     (depth),
        .empty     (empty),
`ifdef RSTK_STACK_ERR_EN
        .full      (full),
        .err_clear (err_clear),
        .overflow  (overflow),
        .underflow (underflow)
`else
        .full      (full)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               dep;
        bit               ovf;
        bit               udf;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model[$];
    bit               m_ovf;
    bit               m_udf;
    int               checks;
    int               errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.dout = (model.size() > 0) ? model[model.size() - 1] : '0;
        e.dep  = model.size();
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        return e;
    endfunction

    // Stack semantics: the queue back is the top, and the queue front is the oldest entry.
    task automatic model_edge(input bit ld, input bit rd, input logic [WIDTH-1:0] din, input bit clr);
        bit oe = 0;
        bit ue = 0;
        if (ld && (!rd || model.size() == 0)) begin
            if (model.size() == DEPTH) begin
                void'(model.pop_front());
                oe = 1;
            end
            model.push_back(din);
        end else if (ld && rd) begin
            model[model.size() - 1] = din;
        end else if (rd) begin
            if (model.size() > 0) void'(model.pop_back());
            else ue = 1;
        end
        if (oe) m_ovf = 1; else if (clr) m_ovf = 0;
        if (ue) m_udf = 1; else if (clr) m_udf = 0;
    endtask

    // Drive one cycle.
    // The expectation recorded is the state visible now, before the next rising edge applies these inputs.
    task automatic step(input bit ld, input bit rd, input logic [WIDTH-1:0] din, input bit clr);
        @(negedge sysclk);
        sysreset  = 1'b1;
        load      = ld;
        read      = rd;
        data_in   = din;
        err_clear = clr;
        exp_q.push_back(snapshot());
        model_edge(ld, rd, din, clr);
    endtask

    task automatic reset_cycle();
        @(negedge sysclk);
        sysreset = 1'b0;
        load     = 1'b0;
        read     = 1'b0;
        exp_q.push_back(snapshot());
    endtask

    // The monitor samples the outputs mid-cycle, well away from the rising edge.
    initial begin
        forever begin
            @(negedge sysclk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.dout));
                chk("depth",    32'(depth),    32'(e.dep));
                chk("empty",    32'(empty),    32'(e.dep == 0));
                chk("full",     32'(full),     32'(e.dep == DEPTH));
`ifdef RSTK_STACK_ERR_EN
                chk("overflow",  32'(overflow),  32'(e.ovf));
                chk("underflow", 32'(underflow), 32'(e.udf));
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        checks    = 0;
        errors    = 0;
        m_ovf     = 0;
        m_udf     = 0;
        sysreset  = 1'b0;
        load      = 1'b0;
        read      = 1'b0;
        data_in   = '0;
        err_clear = 1'b0;

        repeat (3) reset_cycle();
        step(0, 0, '0, 0);

        // Push three values, then pop them back in reverse order.
        step(1, 0, 16'h1111, 0);
        step(1, 0, 16'h2222, 0);
        step(1, 0, 16'h3333, 0);
        repeat (3) step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Push one past the depth to force a wrap, then pop everything plus one more.
        for (int i = 0; i <= DEPTH; i++) step(1, 0, WIDTH'(i), 0);
        for (int i = 0; i <= DEPTH; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);

        // Replace-top on a one-entry stack, then load and read together on an empty stack.
        step(1, 0, 16'hAAAA, 0);
        step(1, 1, 16'h5555, 0);
        step(0, 1, '0, 0);
        step(1, 1, 16'h5555, 0);
        step(0, 1, '0, 0);

        // Sticky underflow, clearing it, and a clear that coincides with a new underflow.
        step(0, 1, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 1, '0, 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);

        // Reset mid-cycle with no rising edge before the next sample.
        for (int i = 0; i < 5; i++) step(1, 0, WIDTH'(16'h0100 + i), 0);
        @(posedge sysclk);
        #1;
        sysreset = 1'b0;
        load     = 1'b0;
        model.delete();
        m_ovf = 0;
        m_udf = 0;
        reset_cycle();
        reset_cycle();
        step(1, 0, 16'h7777, 0);
        step(0, 0, '0, 0);

        // Random traffic with a push bias so that the stack regularly fills and wraps.
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 99));
            bit ld = (r < 55) || (r >= 90);
            bit rd = (r >= 55);
            bit clr = ($urandom_range(0, 15) == 0);
            if (i % 400 == 300) begin
                ld = 0;
                rd = 1;
            end
            step(ld, rd, WIDTH'($urandom), clr);
        end
        step(0, 0, '0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge sysclk);
            #5;
            wait_cycles++;
        end
        @(negedge sysclk);
        #5;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
